// File: rtl/debug_controller.sv
// UART-driven debug controller: loads instruction memory, runs or single-steps
// the datapath, then dumps PC, register file and data memory over the UART.
module debug_controller #(
  parameter int NB_DATA    = 32,
  parameter int NB_RB_ADDR = 5,
  parameter int NB_DM_ADDR = 5,
  parameter int NB_IM_ADDR = 8,
  parameter int NB_STATE   = 10
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_hlt,
  input  logic                  i_rx_done,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_tx_done,
  input  logic [NB_DATA-1:0]    i_pc_value,
  input  logic [NB_DATA-1:0]    i_rb_data,
  input  logic [NB_DATA-1:0]    i_dm_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_im_write_enable,
  output logic [NB_IM_ADDR-1:0] o_im_addr,
  output logic [7:0]            o_im_data,
  output logic [NB_RB_ADDR-1:0] o_rb_addr,
  output logic [NB_DM_ADDR-1:0] o_dm_addr,
  output logic                  o_dm_du_flag,
  output logic                  o_pipeline_enable,
  output logic [NB_STATE-1:0]   o_state
);

  // Handshakes: i_rx_done is a one-cycle pulse qualifying i_rx_data; o_tx_start is a
  // one-cycle pulse with o_tx_data held until the next start; exactly one i_tx_done
  // pulse is awaited per start, any other i_tx_done is dropped.
  typedef enum logic [9:0] {
    ST_IDLE      = 10'b0000000001,
    ST_LOAD_LEN  = 10'b0000000010,
    ST_LOAD_DATA = 10'b0000000100,
    ST_RUN       = 10'b0000001000,
    ST_STEP_IDLE = 10'b0000010000,
    ST_STEP_EXEC = 10'b0000100000,
    ST_DUMP_PC   = 10'b0001000000,
    ST_DUMP_RB   = 10'b0010000000,
    ST_DUMP_DM   = 10'b0100000000,
    ST_DUMP_END  = 10'b1000000000
  } state_t;

  typedef enum logic [1:0] {PH_ADDR, PH_CAP, PH_START, PH_WAIT} phase_t;

  localparam logic [7:0]  LAST_BYTE = 8'(NB_DATA / 8 - 1);
  localparam logic [15:0] RB_LAST   = 16'((1 << NB_RB_ADDR) - 1);
  localparam logic [15:0] DM_LAST   = 16'((1 << NB_DM_ADDR) - 1);

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic                  got_lo_q, got_lo_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           k_q, k_d;
  logic [NB_DATA-1:0]    word_q, word_d;
  logic [7:0]            byte_idx_q, byte_idx_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic                  from_run_q, from_run_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  im_we_q, im_we_d;
  logic [NB_IM_ADDR-1:0] im_addr_q, im_addr_d;
  logic [7:0]            im_data_q, im_data_d;
  logic [NB_RB_ADDR-1:0] rb_addr_q, rb_addr_d;
  logic [NB_DM_ADDR-1:0] dm_addr_q, dm_addr_d;
  logic                  dm_flag_q, dm_flag_d;
  logic                  pe_q, pe_d;
  logic                  im_in_range;
  logic                  last_word;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    got_lo_d    = got_lo_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    k_d         = k_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    from_run_d  = from_run_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_data_d   = im_data_q;
    rb_addr_d   = rb_addr_q;
    dm_addr_d   = dm_addr_q;
    // Bytes beyond the instruction memory are swallowed rather than wrapped.
    im_in_range = ((32'(k_q) >> NB_IM_ADDR) == 32'd0);
    last_word   = (state_q == ST_DUMP_RB) ? (word_idx_q == RB_LAST) : (word_idx_q == DM_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == 8'h4C) begin
            state_d  = ST_LOAD_LEN;
            got_lo_d = 1'b0;
          end else if (i_rx_data == 8'h43) begin
            state_d    = ST_RUN;
            from_run_d = 1'b1;
          end else if (i_rx_data == 8'h53) begin
            state_d = ST_STEP_IDLE;
          end
        end
      end
      ST_LOAD_LEN: begin
        if (i_rx_done) begin
          if (!got_lo_q) begin
            len_lo_d = i_rx_data;
            got_lo_d = 1'b1;
          end else begin
            got_lo_d = 1'b0;
            len_d    = {i_rx_data, len_lo_q};
            k_d      = 16'd0;
            state_d  = ({i_rx_data, len_lo_q} == 16'd0) ? ST_IDLE : ST_LOAD_DATA;
          end
        end
      end
      ST_LOAD_DATA: begin
        if (i_rx_done) begin
          im_addr_d = NB_IM_ADDR'(k_q);
          im_data_d = i_rx_data;
          im_we_d   = im_in_range;
          k_d       = k_q + 16'd1;
          if (k_q == len_q - 16'd1) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_hlt) begin
          state_d    = ST_DUMP_PC;
          phase_d    = PH_ADDR;
          word_idx_d = 16'd0;
        end
      end
      ST_STEP_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == 8'h4E) begin
            state_d    = ST_STEP_EXEC;
            from_run_d = 1'b0;
          end else if (i_rx_data == 8'h58) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_STEP_EXEC: begin
        state_d    = ST_DUMP_PC;
        phase_d    = PH_ADDR;
        word_idx_d = 16'd0;
      end
      ST_DUMP_PC, ST_DUMP_RB, ST_DUMP_DM: begin
        unique case (phase_q)
          // Address was registered last cycle; memory data lands one cycle later.
          PH_ADDR: phase_d = PH_CAP;
          PH_CAP: begin
            word_d     = (state_q == ST_DUMP_PC) ? i_pc_value :
                         (state_q == ST_DUMP_RB) ? i_rb_data : i_dm_data;
            byte_idx_d = 8'd0;
            phase_d    = PH_START;
          end
          PH_START: begin
            tx_data_d  = 8'(word_q >> {byte_idx_q, 3'b000});
            tx_start_d = 1'b1;
            phase_d    = PH_WAIT;
          end
          PH_WAIT: begin
            if (i_tx_done) begin
              if (byte_idx_q != LAST_BYTE) begin
                byte_idx_d = byte_idx_q + 8'd1;
                phase_d    = PH_START;
              end else begin
                phase_d    = PH_ADDR;
                word_idx_d = word_idx_q + 16'd1;
                if (state_q == ST_DUMP_PC) begin
                  state_d    = ST_DUMP_RB;
                  word_idx_d = 16'd0;
                  rb_addr_d  = '0;
                end else if (state_q == ST_DUMP_RB) begin
                  if (last_word) begin
                    state_d    = ST_DUMP_DM;
                    word_idx_d = 16'd0;
                    dm_addr_d  = '0;
                  end else begin
                    rb_addr_d = NB_RB_ADDR'(word_idx_q + 16'd1);
                  end
                end else begin
                  if (last_word) state_d = ST_DUMP_END;
                  else dm_addr_d = NB_DM_ADDR'(word_idx_q + 16'd1);
                end
              end
            end
          end
          default: phase_d = PH_ADDR;
        endcase
      end
      ST_DUMP_END: state_d = (from_run_q || i_hlt) ? ST_IDLE : ST_STEP_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    pe_d      = (state_d == ST_RUN) || (state_d == ST_STEP_EXEC);
    dm_flag_d = (state_d == ST_DUMP_DM);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_ADDR;
      got_lo_q   <= 1'b0;
      len_lo_q   <= 8'd0;
      len_q      <= 16'd0;
      k_q        <= 16'd0;
      word_q     <= '0;
      byte_idx_q <= 8'd0;
      word_idx_q <= 16'd0;
      from_run_q <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_data_q  <= 8'd0;
      rb_addr_q  <= '0;
      dm_addr_q  <= '0;
      dm_flag_q  <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      got_lo_q   <= got_lo_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      k_q        <= k_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      from_run_q <= from_run_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_data_q  <= im_data_d;
      rb_addr_q  <= rb_addr_d;
      dm_addr_q  <= dm_addr_d;
      dm_flag_q  <= dm_flag_d;
      pe_q       <= pe_d;
    end
  end

  assign o_tx_data         = tx_data_q;
  assign o_tx_start        = tx_start_q;
  assign o_im_write_enable = im_we_q;
  assign o_im_addr         = im_addr_q;
  assign o_im_data         = im_data_q;
  assign o_rb_addr         = rb_addr_q;
  assign o_dm_addr         = dm_addr_q;
  assign o_dm_du_flag      = dm_flag_q;
  assign o_pipeline_enable = pe_q;
  assign o_state           = NB_STATE'(state_q);

endmodule

// File: tb/tb_debug_controller.sv
// Bench for debug_controller: UART byte driver, UART transmitter responder,
// register/data memory models and a byte-level reference of the dump stream.
module tb_debug_controller;

  localparam logic [9:0] S_IDLE      = 10'b0000000001;
  localparam logic [9:0] S_RUN       = 10'b0000001000;
  localparam logic [9:0] S_STEP_IDLE = 10'b0000010000;
  localparam logic [9:0] S_STEP_EXEC = 10'b0000100000;
  localparam logic [9:0] S_DUMP_DM   = 10'b0100000000;

  // ---------------- clock / reset / signals ----------------
  logic        i_clock = 1'b0;
  logic        i_reset, i_hlt, i_rx_done;
  logic [7:0]  i_rx_data;
  logic        i_tx_done = 1'b0;
  logic [31:0] i_pc_value;
  logic [31:0] i_rb_data = 32'd0;
  logic [31:0] i_dm_data = 32'd0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, o_im_write_enable;
  logic [7:0]  o_im_addr, o_im_data;
  logic [4:0]  o_rb_addr, o_dm_addr;
  logic        o_dm_du_flag, o_pipeline_enable;
  logic [9:0]  o_state;

  always #5 i_clock = ~i_clock;

  debug_controller dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_hlt(i_hlt),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .i_tx_done(i_tx_done),
    .i_pc_value(i_pc_value), .i_rb_data(i_rb_data), .i_dm_data(i_dm_data),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_im_write_enable(o_im_write_enable), .o_im_addr(o_im_addr), .o_im_data(o_im_data),
    .o_rb_addr(o_rb_addr), .o_dm_addr(o_dm_addr), .o_dm_du_flag(o_dm_du_flag),
    .o_pipeline_enable(o_pipeline_enable), .o_state(o_state)
  );

  // ---------------- memory models (one-cycle read latency) ----------------
  logic [31:0] rb_mem [32];
  logic [31:0] dm_mem [32];
  always @(posedge i_clock) begin
    i_rb_data <= rb_mem[o_rb_addr];
    i_dm_data <= dm_mem[o_dm_addr];
  end

  // ---------------- UART responder and output monitor ----------------
  int          cyc = 0, pe_cnt = 0, viol = 0, rule_err = 0, tx_cnt = 0;
  int          tx_delay = 1;
  bit          pend = 0, prev_start = 0;
  logic [7:0]  tx_got_q[$];
  int          start_cyc_q[$];
  logic [15:0] wr_q[$];

  always @(negedge i_clock) begin
    if (i_tx_done) i_tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) begin
        i_tx_done = 1'b1;
        pend = 0;
      end
    end
    if (o_tx_start) begin
      if (pend || prev_start) viol = viol + 1;
      tx_got_q.push_back(o_tx_data);
      start_cyc_q.push_back(cyc);
      pend   = 1;
      tx_cnt = tx_delay;
    end
    prev_start = o_tx_start;
    if (o_im_write_enable) wr_q.push_back({o_im_addr, o_im_data});
    if (o_pipeline_enable) pe_cnt = pe_cnt + 1;
    if (!$onehot(o_state)) rule_err = rule_err + 1;
    if (o_dm_du_flag !== (o_state == S_DUMP_DM)) rule_err = rule_err + 1;
    if (o_pipeline_enable && !(o_state == S_RUN || o_state == S_STEP_EXEC)) rule_err = rule_err + 1;
    cyc = cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int          total = 0, bad = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  load_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, o_state, S_IDLE);
    check({tag, "_tx"}, {o_tx_start, o_tx_data}, 9'd0);
    check({tag, "_im"}, {o_im_write_enable, o_im_addr, o_im_data}, 17'd0);
    check({tag, "_addr"}, {o_rb_addr, o_dm_addr}, 10'd0);
    check({tag, "_flags"}, {o_dm_du_flag, o_pipeline_enable}, 2'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clock);
    i_rx_done = 1'b1;
    i_rx_data = b;
    @(negedge i_clock);
    i_rx_done = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge i_clock);
  endtask

  task automatic wait_state(input logic [9:0] tgt, input int budget, input string tag);
    int n = 0;
    while (o_state !== tgt && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    check(tag, o_state, tgt);
  endtask

  task automatic wait_bytes(input int count, input int budget, input string tag);
    int n = 0;
    while (tx_got_q.size() < count && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    check(tag, tx_got_q.size() >= count, 1'b1);
  endtask

  // Sends 'L', a 16-bit length and load_q, then compares the write strobes.
  task automatic do_load(input string tag);
    int base = wr_q.size();
    int n = load_q.size();
    int mis = 0;
    exp_wr_q.delete();
    for (int k = 0; k < n; k++)
      if (k < 256) exp_wr_q.push_back({8'(k), load_q[k]});
    send_byte(8'h4C);
    send_byte(8'(n % 256));
    send_byte(8'(n / 256));
    for (int k = 0; k < n; k++) send_byte(load_q[k]);
    repeat (3) @(negedge i_clock);
    check({tag, "_count"}, wr_q.size() - base, exp_wr_q.size());
    for (int i = 0; i < exp_wr_q.size() && base + i < wr_q.size(); i++)
      if (wr_q[base + i] !== exp_wr_q[i]) mis++;
    check({tag, "_writes"}, mis, 0);
    wait_state(S_IDLE, 10, {tag, "_idle"});
  endtask

  task automatic fill_mems();
    for (int i = 0; i < 32; i++) begin
      rb_mem[i] = $urandom();
      dm_mem[i] = $urandom();
    end
  endtask

  // Reference dump: PC, then every register, then every data word, LSB first.
  task automatic build_dump(input logic [31:0] pc);
    logic [31:0] words[$];
    exp_q.delete();
    words.push_back(pc);
    for (int i = 0; i < 32; i++) words.push_back(rb_mem[i]);
    for (int i = 0; i < 32; i++) words.push_back(dm_mem[i]);
    foreach (words[w])
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((words[w] / (32'd1 << (8 * b))) % 256));
  endtask

  task automatic compare_dump(input int base, input string tag);
    int mis = 0;
    check({tag, "_len"}, tx_got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < tx_got_q.size(); i++)
      if (tx_got_q[base + i] !== exp_q[i]) mis++;
    check({tag, "_bytes"}, mis, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, pe_base, wr_base, min_gap;
    logic [7:0] junk;
    i_reset = 1'b0; i_hlt = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'd0;
    i_pc_value = 32'd0;
    fill_mems();
    repeat (3) @(negedge i_clock);
    check_reset_outputs("reset");
    i_reset = 1'b1;
    @(negedge i_clock);

    // Directed load of three bytes
    load_q = '{8'hAA, 8'hBB, 8'hCC};
    do_load("load3");

    // Zero-length load
    load_q.delete();
    do_load("load0");

    // Unknown byte in IDLE, then a load running past the instruction memory
    do junk = 8'($urandom_range(0, 255)); while (junk == 8'h4C || junk == 8'h43 || junk == 8'h53);
    send_byte(junk);
    wait_state(S_IDLE, 2, "idle_ignore");
    load_q.delete();
    for (int k = 0; k < 258; k++) load_q.push_back(8'($urandom_range(0, 255)));
    do_load("load258");

    // Run until halt after ten enabled cycles
    i_pc_value = 32'h0000_0024;
    fill_mems();
    build_dump(i_pc_value);
    base    = tx_got_q.size();
    pe_base = pe_cnt;
    @(negedge i_clock);
    i_rx_done = 1'b1;
    i_rx_data = 8'h43;
    @(negedge i_clock);
    i_rx_done = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge i_clock);
    i_hlt = 1'b1;
    wait_state(S_IDLE, 6000, "run_end_idle");
    check("run_pe_cycles", pe_cnt - pe_base, 10);
    for (int b = 0; b < 4; b++)
      if (base + b < tx_got_q.size()) check($sformatf("run_pc_b%0d", b), tx_got_q[base + b], exp_q[b]);
    compare_dump(base, "run_dump");
    i_hlt = 1'b0;

    // Single step with UART bytes arriving during the dump
    i_pc_value = $urandom();
    fill_mems();
    build_dump(i_pc_value);
    tx_delay = $urandom_range(1, 4);
    base    = tx_got_q.size();
    pe_base = pe_cnt;
    send_byte(8'h53);
    wait_state(S_STEP_IDLE, 10, "step_enter");
    do junk = 8'($urandom_range(0, 255)); while (junk == 8'h4E || junk == 8'h58);
    send_byte(junk);
    wait_state(S_STEP_IDLE, 2, "step_ignore");
    send_byte(8'h4E);
    repeat (20) @(negedge i_clock);
    send_byte(8'h58);
    send_byte(8'h43);
    wait_state(S_STEP_IDLE, 8000, "step_back");
    check("step_pe_cycles", pe_cnt - pe_base, 1);
    compare_dump(base, "step_dump");
    send_byte(8'h58);
    wait_state(S_IDLE, 10, "step_exit");

    // Throttled transmitter, then reset in the middle of the dump
    tx_delay = 50;
    base = tx_got_q.size();
    send_byte(8'h53);
    wait_state(S_STEP_IDLE, 10, "thr_enter");
    send_byte(8'h4E);
    wait_bytes(base + 4, 1000, "thr_four_bytes");
    min_gap = 1000;
    for (int i = 1; i < 4 && base + i < start_cyc_q.size(); i++)
      if (start_cyc_q[base + i] - start_cyc_q[base + i - 1] < min_gap)
        min_gap = start_cyc_q[base + i] - start_cyc_q[base + i - 1];
    check("thr_gap_over_50", min_gap > 50, 1'b1);
    tx_delay = 1;
    wait_bytes(base + 100, 5000, "rst_reach_byte100");
    i_reset = 1'b0;
    @(negedge i_clock);
    check_reset_outputs("midreset");
    i_reset = 1'b1;
    base    = tx_got_q.size();
    wr_base = wr_q.size();
    repeat (200) @(negedge i_clock);
    check("post_reset_no_tx", tx_got_q.size() - base, 0);
    check("post_reset_no_wr", wr_q.size() - wr_base, 0);
    check("post_reset_idle", o_state, S_IDLE);

    check("tx_protocol", viol, 0);
    check("output_rules", rule_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
